// File: rtl/layer_seq_if.sv
// Bus bundle between the layer sequencer and its frame buffer, layer datapath and result sink.
// The master side is the sequencer; the slave side is the surrounding environment.
interface layer_seq_if #(
  parameter int unsigned DIM = 32,
  parameter int unsigned K   = 5
);
  localparam int unsigned NPIX   = DIM * DIM;
  localparam int unsigned SIDE   = (DIM - K + 1) / 2;
  localparam int unsigned NOUT   = SIDE * SIDE;
  localparam int unsigned ADDR_W = $clog2(NPIX);
  localparam int unsigned POS_W  = $clog2(NOUT);

  logic                    mem_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [7:0]              mem_rdata;
  logic signed [8:0]       pxl_out;
  logic                    pxl_valid;
  logic                    layer_rst;
  logic                    layer_valid;
  logic signed [8:0]       layer_out;
  logic                    res_valid;
  logic signed [8:0]       res_data;
  logic [POS_W-1:0]        res_row;
  logic [POS_W-1:0]        res_col;

  modport master (
    output mem_en, mem_addr, pxl_out, pxl_valid, layer_rst,
           res_valid, res_data, res_row, res_col,
    input  mem_rdata, layer_valid, layer_out
  );

  modport slave (
    input  mem_en, mem_addr, pxl_out, pxl_valid, layer_rst,
           res_valid, res_data, res_row, res_col,
    output mem_rdata, layer_valid, layer_out
  );
endinterface

// File: rtl/layer_seq.sv
// Frame sequencer: clears the layer, streams one DIM x DIM frame into it and collects
// the NOUT results into an output grid, with abort, overflow and drain-timeout handling.
module layer_seq #(
  parameter int unsigned DIM       = 32,
  parameter int unsigned K         = 5,
  parameter int unsigned DRAIN_MAX = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  layer_seq_if.master   bus,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int unsigned NPIX   = DIM * DIM;
  localparam int unsigned SIDE   = (DIM - K + 1) / 2;
  localparam int unsigned NOUT   = SIDE * SIDE;
  localparam int unsigned ADDR_W = $clog2(NPIX);
  localparam int unsigned POS_W  = $clog2(NOUT);
  localparam int unsigned CNT_W  = $clog2(NOUT + 1);
  localparam int unsigned DRN_W  = $clog2(DRAIN_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic                clr_q, clr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [POS_W-1:0]    row_q, row_d, col_q, col_d;
  logic [DRN_W-1:0]    drn_q, drn_d;
  logic                mem_en_q, mem_en_d;
  logic                pxl_valid_q, pxl_valid_d;
  logic                layer_rst_q, layer_rst_d;
  logic                res_valid_q, res_valid_d;
  logic signed [8:0]   res_data_q, res_data_d;
  logic [POS_W-1:0]    res_row_q, res_row_d, res_col_q, res_col_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                abort_hit, take, accept;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    drn_d       = drn_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_row_d   = res_row_q;
    res_col_d   = res_col_q;
    err_d       = err_q;

    abort_hit = abort && (state_q == S_CLEAR || state_q == S_STREAM || state_q == S_DRAIN);
    take      = bus.layer_valid && (state_q == S_STREAM || state_q == S_DRAIN) && !abort_hit;
    accept    = take && (cnt_q < CNT_W'(NOUT));

    // A result beyond the full grid is dropped and flagged
    if (take && !accept && state_q == S_STREAM) err_d = 1'b1;

    if (accept) begin
      res_valid_d = 1'b1;
      res_data_d  = bus.layer_out;
      res_row_d   = row_q;
      res_col_d   = col_q;
      cnt_d       = cnt_q + CNT_W'(1);
      if (col_q == POS_W'(SIDE - 1)) begin
        col_d = '0;
        row_d = row_q + POS_W'(1);
      end else begin
        col_d = col_q + POS_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLEAR;
          clr_d     = 1'b0;
          addr_d    = '0;
          cnt_d     = '0;
          row_d     = '0;
          col_d     = '0;
          drn_d     = '0;
          res_row_d = '0;
          res_col_d = '0;
          err_d     = 1'b0;
        end
      end
      S_CLEAR: begin
        if (clr_q) state_d = S_STREAM;
        else       clr_d   = 1'b1;
      end
      S_STREAM: begin
        if (addr_q == ADDR_W'(NPIX - 1)) begin
          state_d = S_DRAIN;
          drn_d   = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_d == CNT_W'(NOUT)) begin
          state_d = S_FIN;
        end else if (drn_q == DRN_W'(DRAIN_MAX - 1)) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition and leaves the error flag as it was
    if (abort_hit) begin
      state_d = S_IDLE;
      err_d   = err_q;
    end

    mem_en_d    = (state_d == S_STREAM);
    pxl_valid_d = mem_en_q;
    layer_rst_d = (state_d == S_CLEAR) || abort_hit;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FIN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      clr_q       <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      drn_q       <= '0;
      mem_en_q    <= 1'b0;
      pxl_valid_q <= 1'b0;
      layer_rst_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_row_q   <= '0;
      res_col_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      drn_q       <= drn_d;
      mem_en_q    <= mem_en_d;
      pxl_valid_q <= pxl_valid_d;
      layer_rst_q <= layer_rst_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_row_q   <= res_row_d;
      res_col_q   <= res_col_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Read data arrives in the pxl_valid cycle, so the pixel is a zero-extended pass-through
  assign bus.pxl_out   = pxl_valid_q ? $signed({1'b0, bus.mem_rdata}) : 9'sd0;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.pxl_valid = pxl_valid_q;
  assign bus.layer_rst = layer_rst_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_row   = res_row_q;
  assign bus.res_col   = res_col_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
endmodule

// File: doc/layer_seq.md
LAYER_SEQ -- requirements
Module: layer_seq

Interface
REQ-001 SHALL have parameter DIM, default 32: input image side in pixels.
REQ-002 SHALL have parameter K, default 5: convolution kernel side.
REQ-003 SHALL have parameter DRAIN_MAX, default 256: maximum cycles spent waiting for trailing results.
REQ-004 SHALL derive local constants NPIX = DIM*DIM and NOUT = ((DIM-K+1)/2)^2, which is 196 at the defaults.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to process one frame.
REQ-008 abort  input  1  cancel the frame in progress.
REQ-009 mem_en  output  1  frame-buffer read enable.
REQ-010 mem_addr  output  clog2(NPIX)  frame-buffer read address.
REQ-011 mem_rdata  input  8  read data, valid one cycle after mem_en.
REQ-012 pxl_out  output  9  signed pixel to the layer: {1'b0, mem_rdata} while pxl_valid=1, otherwise 0.
REQ-013 pxl_valid  output  1  pxl_out carries a frame pixel.
REQ-014 layer_rst  output  1  active-high reset to the layer datapath.
REQ-015 layer_valid  input  1  layer result strobe.
REQ-016 layer_out  input  9  signed layer result.
REQ-017 res_valid  output  1  registered copy of an accepted result.
REQ-018 res_data  output  9  accepted result, registered.
REQ-019 res_row, res_col  output  clog2(NOUT)  position of the result in the output grid.
REQ-020 busy  output  1  high in any state other than IDLE.
REQ-021 done  output  1  one-cycle completion pulse.
REQ-022 err  output  1  sticky error flag; cleared only by the next accepted start.

Function
REQ-023 SHALL implement the states IDLE, CLEAR, STREAM, DRAIN and FIN.
REQ-024 In IDLE, start=1 SHALL move to CLEAR, clear err, and zero the address, result count, res_row and res_col; start while busy=1 SHALL be ignored.
REQ-025 CLEAR SHALL hold layer_rst=1 for exactly 2 cycles and then enter STREAM; layer_rst SHALL be 0 in every other state.
REQ-026 STREAM SHALL assert mem_en for exactly NPIX consecutive cycles with mem_addr = 0, 1, ..., NPIX-1, and then enter DRAIN.
REQ-027 pxl_valid SHALL equal mem_en delayed by one cycle, giving first pixel = address 0 one cycle after the first mem_en.
REQ-028 During STREAM and DRAIN, layer_valid=1 SHALL produce, in the next cycle, res_valid=1 with res_data=layer_out and the current res_row/res_col.
REQ-029 After each accepted result, res_col SHALL increment; at res_col = sqrt(NOUT)-1 it SHALL wrap to 0 and res_row SHALL increment.
REQ-030 A result counter SHALL increment per accepted result.
REQ-031 DRAIN SHALL enter FIN when the result count reaches NOUT.
REQ-032 DRAIN SHALL enter FIN and set err after DRAIN_MAX cycles without completion.
REQ-033 A layer_valid arriving in STREAM with the count already at NOUT SHALL set err and be discarded.
REQ-034 In IDLE, CLEAR and FIN, layer_valid SHALL be ignored and SHALL NOT set err.
REQ-035 FIN SHALL assert done=1 for one cycle and return to IDLE; start in the FIN cycle SHALL be ignored.
REQ-036 abort=1 in CLEAR, STREAM or DRAIN SHALL, next cycle, deassert mem_en, enter IDLE and pulse layer_rst for 1 cycle, with no done pulse and err unchanged.
REQ-037 abort in IDLE or FIN SHALL have no effect.
REQ-038 abort SHALL take priority over every other transition in the same cycle.
REQ-039 pxl_valid SHALL still follow a mem_en issued in the abort cycle.
REQ-040 All counters SHALL be wide enough never to wrap within one frame.

Reset
REQ-041 reset=0 SHALL immediately force IDLE, with mem_en, pxl_valid, res_valid, done, busy and err = 0, layer_rst = 1, and mem_addr, res_data, res_row and res_col = 0.
REQ-042 After reset deasserts, layer_rst SHALL drop on the first clock edge.
REQ-043 reset asserted mid-frame SHALL behave as in REQ-041, and no done pulse SHALL follow.

Verification
REQ-044 Nominal run: model memory with data = (addr+1) mod 256, model layer emitting 196 valids -> 1024 mem_en cycles, addresses 0..1023, pxl_out 1..255,0,1..., exactly 196 res_valid with last res_row=13 and res_col=13, done once, err=0.
REQ-045 Start while busy: second start during STREAM -> ignored; exactly 1024 reads and one done.
REQ-046 Short layer: model emits only 150 valids -> DRAIN times out after 256 cycles, then done=1 and err=1; err clears on the next start.
REQ-047 Abort: abort asserted at read address 500 -> mem_en low next cycle, one-cycle layer_rst pulse, busy=0, no done; a following start runs cleanly from address 0.
REQ-048 Reset mid-DRAIN: reset=0 for 3 cycles -> all outputs at reset values asynchronously, no done, layer_rst high while reset is low.
REQ-049 Overflow: model emits 197 valids during STREAM -> err=1, and res_valid is not asserted for the 197th valid.
